// File: rtl/fetch_pc_if.sv
// Bundle between the fetch PC controller and the decode/execute/control side.
// The slave modport is the controller's view of the bundle.
interface fetch_pc_if;
    logic        stall;
    logic        id_branch;
    logic        id_call;
    logic        id_ret;
    logic        alu_done;
    logic        update_done;
    logic [15:0] PC_update;
    logic        PC_src;
    logic [15:0] PC_out;
    logic        fetch_valid;
    logic        flush_IF_ID;
    logic        hault;
    logic [15:0] ret_addr;
    logic        redirect_err;

    modport master (
        output stall, id_branch, id_call, id_ret,
        output alu_done, update_done, PC_update, PC_src,
        input  PC_out, fetch_valid, flush_IF_ID, hault, ret_addr, redirect_err
    );

    modport slave (
        input  stall, id_branch, id_call, id_ret,
        input  alu_done, update_done, PC_update, PC_src,
        output PC_out, fetch_valid, flush_IF_ID, hault, ret_addr, redirect_err
    );
endinterface

// File: rtl/fetch_pc_ctrl.sv
// Fetch-side PC owner: sequential increment, halt/squash on control ops,
// redirect load from execute, and a watchdog on the redirect wait.
module fetch_pc_ctrl #(
    parameter logic [15:0] RESET_PC = 16'h0000,
    parameter int unsigned WAIT_MAX = 15
) (
    input  logic       clk,
    input  logic       rst_n,
    fetch_pc_if.slave  bus
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_WAIT_BR = 2'd1,
        ST_WAIT_CR = 2'd2
    } state_t;

    localparam logic [8:0] WAIT_LIMIT = 9'(WAIT_MAX);

    state_t      state_q, state_d;
    logic [15:0] pc_q, pc_d;
    logic [15:0] ret_addr_q, ret_addr_d;
    logic [7:0]  wait_cnt_q, wait_cnt_d;
    logic        err_q, err_d;
    logic        flush_q, flush_d;
    logic        hault_q, hault_d;
    logic        started_q;

    logic ctrl_op;
    logic strobe_ok;
    logic wd_fire;

    assign ctrl_op   = bus.id_branch | bus.id_call | bus.id_ret;
    assign strobe_ok = bus.alu_done | ((state_q == ST_WAIT_CR) & bus.update_done);
    assign wd_fire   = (({1'b0, wait_cnt_q} + 9'd1) == WAIT_LIMIT);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        ret_addr_d = ret_addr_q;
        wait_cnt_d = wait_cnt_q;
        err_d      = err_q;
        flush_d    = 1'b0;
        hault_d    = hault_q;

        case (state_q)
            ST_RUN: begin
                // The first cycle out of reset issues no fetch, so nothing advances.
                if (started_q && !bus.stall) begin
                    if (ctrl_op) begin
                        flush_d    = 1'b1;
                        hault_d    = 1'b1;
                        wait_cnt_d = 8'd0;
                        if (bus.id_branch) begin
                            state_d = ST_WAIT_BR;
                        end else begin
                            state_d = ST_WAIT_CR;
                            if (bus.id_call) begin
                                ret_addr_d = pc_q;
                            end
                        end
                    end else begin
                        pc_d = pc_q + 16'd1;
                    end
                end
            end
            ST_WAIT_BR, ST_WAIT_CR: begin
                if (strobe_ok) begin
                    if (bus.PC_src) begin
                        pc_d = bus.PC_update;
                    end
                    state_d = ST_RUN;
                    hault_d = 1'b0;
                end else if (wd_fire) begin
                    // Give up on the redirect; PC stays on the fall-through address.
                    err_d   = 1'b1;
                    state_d = ST_RUN;
                    hault_d = 1'b0;
                end else begin
                    wait_cnt_d = wait_cnt_q + 8'd1;
                end
            end
            default: begin
                state_d = ST_RUN;
                hault_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_RUN;
            pc_q       <= RESET_PC;
            ret_addr_q <= 16'h0000;
            wait_cnt_q <= 8'd0;
            err_q      <= 1'b0;
            flush_q    <= 1'b0;
            hault_q    <= 1'b0;
            started_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            ret_addr_q <= ret_addr_d;
            wait_cnt_q <= wait_cnt_d;
            err_q      <= err_d;
            flush_q    <= flush_d;
            hault_q    <= hault_d;
            started_q  <= 1'b1;
        end
    end

    assign bus.PC_out       = pc_q;
    assign bus.fetch_valid  = started_q & (state_q == ST_RUN) & ~bus.stall;
    assign bus.flush_IF_ID  = flush_q;
    assign bus.hault        = hault_q;
    assign bus.ret_addr     = ret_addr_q;
    assign bus.redirect_err = err_q;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Directed scenarios followed by random traffic, all checked cycle by cycle
// against a behavioural model of the fetch PC controller.
module tb_fetch_pc_ctrl;

    localparam logic [15:0] RST_PC = 16'hFFFE;
    localparam int          WMAX   = 4;

    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fetch_pc_if bus();

    fetch_pc_ctrl #(.RESET_PC(RST_PC), .WAIT_MAX(WMAX)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int n_checks = 0;
    int n_fail   = 0;

    // Model: mode 0 = fetching, 1 = awaiting branch resolve, 2 = awaiting call/ret redirect
    int m_pc, m_mode, m_waited, m_ret;
    bit m_err, m_started, m_flush;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_pc = int'(RST_PC);
        m_mode = 0;
        m_waited = 0;
        m_ret = 0;
        m_err = 0;
        m_started = 0;
        m_flush = 0;
    endtask

    task automatic model_step(input logic s, input logic br, input logic ca, input logic re,
                              input logic al, input logic up, input logic src, input logic [15:0] tgt);
        m_flush = 0;
        if (!m_started) begin
            m_started = 1;
            return;
        end
        if (m_mode == 0) begin
            if (s) return;
            if (br || ca || re) begin
                m_flush = 1;
                m_waited = 0;
                if (br) m_mode = 1;
                else begin
                    m_mode = 2;
                    if (ca) m_ret = m_pc;
                end
                $display("TXN op %s at pc=%04h", br ? "branch" : (ca ? "call" : "ret"), m_pc[15:0]);
            end else begin
                m_pc = (m_pc + 1) % 65536;
            end
        end else if (al || (m_mode == 2 && up)) begin
            if (src) m_pc = int'(tgt);
            m_mode = 0;
            $display("TXN redirect src=%0d pc=%04h", src, m_pc[15:0]);
        end else begin
            m_waited++;
            if (m_waited >= WMAX) begin
                m_err = 1;
                m_mode = 0;
                $display("TXN watchdog timeout pc=%04h", m_pc[15:0]);
            end
        end
    endtask

    task automatic check_regs();
        check_val("pc_out", bus.PC_out, m_pc);
        check_val("flush", bus.flush_IF_ID, m_flush);
        check_val("hault", bus.hault, m_mode != 0);
        check_val("ret_addr", bus.ret_addr, m_ret);
        check_val("redirect_err", bus.redirect_err, m_err);
    endtask

    task automatic cycle(input logic s, input logic br, input logic ca, input logic re,
                         input logic al, input logic up, input logic src, input logic [15:0] tgt);
        bus.stall = s;
        bus.id_branch = br;
        bus.id_call = ca;
        bus.id_ret = re;
        bus.alu_done = al;
        bus.update_done = up;
        bus.PC_src = src;
        bus.PC_update = tgt;
        #1;
        check_val("fetch_valid", bus.fetch_valid, m_started && m_mode == 0 && !s);
        @(posedge clk);
        model_step(s, br, ca, re, al, up, src, tgt);
        #1;
        check_regs();
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0, 16'h0000);
    endtask

    task automatic assert_reset();
        rst_n = 1'b0;
        #1;
        model_reset();
        check_regs();
        check_val("rst_fetch_valid", bus.fetch_valid, 0);
    endtask

    task automatic release_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        bus.stall = 0; bus.id_branch = 0; bus.id_call = 0; bus.id_ret = 0;
        bus.alu_done = 0; bus.update_done = 0; bus.PC_src = 0; bus.PC_update = 16'h0000;
        model_reset();
        #2;
        assert_reset();
        check_val("rst_pc_const", bus.PC_out, 16'hFFFE);
        release_reset();

        // Sequential fetch and wrap
        check_val("fv_first_cycle", bus.fetch_valid, 0);
        idle(); check_val("wrap0", bus.PC_out, 16'hFFFE);
        check_val("fv_second_cycle", bus.fetch_valid, 1);
        idle(); check_val("wrap1", bus.PC_out, 16'hFFFF);
        idle(); check_val("wrap2", bus.PC_out, 16'h0000);
        idle(); check_val("wrap3", bus.PC_out, 16'h0001);
        for (int i = 0; i < 64 && m_pc != 16'h0010; i++) idle();
        check_val("reach_0010", bus.PC_out, 16'h0010);

        // Taken branch
        cycle(0, 1, 0, 0, 0, 0, 0, 16'h0000);
        check_val("br_flush", bus.flush_IF_ID, 1);
        check_val("br_hault1", bus.hault, 1);
        check_val("br_pc_hold", bus.PC_out, 16'h0010);
        idle();
        check_val("br_flush_once", bus.flush_IF_ID, 0);
        check_val("br_hault2", bus.hault, 1);
        cycle(0, 0, 0, 0, 1, 0, 1, 16'h0040);
        check_val("br_taken_pc", bus.PC_out, 16'h0040);
        check_val("br_hault_off", bus.hault, 0);

        // Untaken branch from 0x0010
        cycle(0, 1, 0, 0, 0, 0, 0, 16'h0000);
        idle();
        cycle(0, 0, 0, 0, 1, 0, 1, 16'h0010);
        cycle(0, 1, 0, 0, 0, 0, 0, 16'h0000);
        idle();
        cycle(0, 0, 0, 0, 1, 0, 0, 16'h7777);
        check_val("nt_refetch", bus.PC_out, 16'h0010);
        idle();
        check_val("nt_next", bus.PC_out, 16'h0011);

        // Call then return
        cycle(0, 1, 0, 0, 0, 0, 0, 16'h0000);
        cycle(0, 0, 0, 0, 1, 0, 1, 16'h0123);
        cycle(0, 0, 1, 0, 0, 0, 0, 16'h0000);
        check_val("call_ret_addr", bus.ret_addr, 16'h0123);
        cycle(0, 0, 0, 0, 0, 1, 1, 16'h0800);
        check_val("call_target", bus.PC_out, 16'h0800);
        idle(); idle();
        cycle(0, 0, 0, 1, 0, 0, 0, 16'h0000);
        cycle(0, 0, 0, 0, 0, 1, 1, 16'h0123);
        check_val("ret_target", bus.PC_out, 16'h0123);

        // Stall/op collision and stray strobe
        cycle(1, 1, 0, 0, 0, 0, 0, 16'h0000);
        check_val("coll_hold", bus.PC_out, 16'h0123);
        check_val("coll_noflush", bus.flush_IF_ID, 0);
        cycle(0, 1, 0, 0, 0, 0, 0, 16'h0000);
        check_val("coll_flush", bus.flush_IF_ID, 1);
        cycle(0, 0, 0, 0, 1, 0, 0, 16'h0000);
        cycle(0, 0, 0, 0, 1, 0, 1, 16'hBEEF);
        check_val("stray_ignored", bus.PC_out, 16'h0124);

        // Watchdog
        cycle(0, 0, 0, 1, 0, 0, 0, 16'h0000);
        idle(); idle(); idle();
        check_val("wd_not_yet", bus.redirect_err, 0);
        idle();
        check_val("wd_err", bus.redirect_err, 1);
        check_val("wd_run", bus.hault, 0);
        check_val("wd_pc_hold", bus.PC_out, 16'h0124);
        idle();
        check_val("wd_sticky", bus.redirect_err, 1);

        // Reset mid-wait
        cycle(0, 1, 0, 0, 0, 0, 0, 16'h0000);
        idle();
        #2;
        assert_reset();
        check_val("rstw_pc", bus.PC_out, 16'hFFFE);
        check_val("rstw_err", bus.redirect_err, 0);
        check_val("rstw_hault", bus.hault, 0);
        check_val("rstw_ret", bus.ret_addr, 16'h0000);
        release_reset();

        // Random traffic
        for (int i = 0; i < 2000; i++) begin
            if ($urandom_range(0, 499) == 0) begin
                assert_reset();
                release_reset();
            end
            cycle($urandom_range(0, 4) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0,
                  $urandom_range(0, 3) == 0, $urandom_range(0, 3) == 0,
                  $urandom_range(0, 1) == 1, 16'($urandom));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
